// File: rtl/sha256_pkg.sv
// Shared SHA-256 definitions: padder FSM states, block geometry and padding constants.
// Also provides the big-endian byte extraction used for the length field.
package sha256_pkg;

  typedef enum logic [1:0] {
    ACCUM = 2'd0,
    PAD   = 2'd1,
    LEN   = 2'd2,
    EMIT  = 2'd3
  } padder_state_e;

  localparam int          BLOCK_BYTES = 64;
  localparam int          LEN_OFFSET  = 56;
  localparam logic [7:0]  PAD_BYTE    = 8'h80;

  // Byte k (0 = most significant) of the 64-bit length field.
  function automatic logic [7:0] len_byte(input logic [63:0] len, input int k);
    logic [63:0] sh;
    sh = len >> (8 * (7 - k));
    return sh[7:0];
  endfunction

endpackage

// File: rtl/sha256_padder.sv
// SHA-256 message padder: packs a byte stream into 512-bit blocks and appends
// the 0x80 marker, zero fill and 64-bit big-endian bit length.
//
// state | meaning
// ACCUM | accepting message bytes into the buffer at idx
// PAD   | write marker at idx, zero the tail, add length if it fits
// LEN   | length-only block (marker did not leave room for the length)
// EMIT  | block presented on the output, waiting for blk_ready
module sha256_padder
  import sha256_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [7:0]   in_data,
  input  logic         in_last,
  output logic         blk_valid,
  input  logic         blk_ready,
  output logic [511:0] blk_data,
  output logic         blk_last,
  output logic         busy
);

  padder_state_e r_state, w_state_nxt;
  logic [6:0]    r_idx, w_idx_nxt;
  logic [63:0]   r_len, w_len_nxt;
  logic          r_msg_end, w_msg_end_nxt;
  logic          r_marker, w_marker_nxt;
  logic          r_blk_last, w_blk_last_nxt;
  logic [7:0]    r_buf [BLOCK_BYTES];
  logic [7:0]    w_buf_nxt [BLOCK_BYTES];

  logic          w_in_xfer;
  logic          w_blk_xfer;
  logic [6:0]    w_idx_inc;
  logic          w_len_fits;

  assign in_ready   = (r_state == ACCUM);
  assign blk_valid  = (r_state == EMIT);
  assign blk_last   = r_blk_last;
  assign busy       = (r_state != ACCUM) || (r_idx != 7'd0);

  assign w_in_xfer  = in_valid && in_ready;
  assign w_blk_xfer = blk_valid && blk_ready;
  assign w_idx_inc  = r_idx + 7'd1;
  assign w_len_fits = (r_idx <= 7'(LEN_OFFSET - 1));

  for (genvar g = 0; g < BLOCK_BYTES; g++) begin : g_out
    assign blk_data[511 - 8*g -: 8] = r_buf[g];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ACCUM;
      r_idx      <= '0;
      r_len      <= '0;
      r_msg_end  <= 1'b0;
      r_marker   <= 1'b0;
      r_blk_last <= 1'b0;
      r_buf      <= '{default: '0};
    end else begin
      r_state    <= w_state_nxt;
      r_idx      <= w_idx_nxt;
      r_len      <= w_len_nxt;
      r_msg_end  <= w_msg_end_nxt;
      r_marker   <= w_marker_nxt;
      r_blk_last <= w_blk_last_nxt;
      r_buf      <= w_buf_nxt;
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_idx_nxt      = r_idx;
    w_len_nxt      = r_len;
    w_msg_end_nxt  = r_msg_end;
    w_marker_nxt   = r_marker;
    w_blk_last_nxt = r_blk_last;
    w_buf_nxt      = r_buf;

    unique case (r_state)
      ACCUM: begin
        if (w_in_xfer) begin
          w_buf_nxt[r_idx[5:0]] = in_data;
          w_idx_nxt             = w_idx_inc;
          w_len_nxt             = r_len + 64'd8;
          if (w_idx_inc == 7'(BLOCK_BYTES)) begin
            w_state_nxt    = EMIT;
            w_blk_last_nxt = 1'b0;
            if (in_last) begin
              w_msg_end_nxt = 1'b1;
              w_marker_nxt  = 1'b0;
            end
          end else if (in_last) begin
            w_msg_end_nxt = 1'b1;
            w_state_nxt   = PAD;
          end
        end
      end

      PAD: begin
        // Stale bytes beyond idx from the previous block must be zeroed here.
        for (int i = 0; i < BLOCK_BYTES; i++) begin
          if (i == int'(r_idx))
            w_buf_nxt[i] = PAD_BYTE;
          else if (i > int'(r_idx))
            w_buf_nxt[i] = 8'h00;
          if (w_len_fits && (i >= LEN_OFFSET))
            w_buf_nxt[i] = len_byte(r_len, i - LEN_OFFSET);
        end
        w_marker_nxt = 1'b1;
        if (w_len_fits)
          w_blk_last_nxt = 1'b1;
        w_state_nxt = EMIT;
      end

      LEN: begin
        for (int i = 0; i < BLOCK_BYTES; i++) begin
          if (i >= LEN_OFFSET)
            w_buf_nxt[i] = len_byte(r_len, i - LEN_OFFSET);
          else
            w_buf_nxt[i] = 8'h00;
        end
        w_blk_last_nxt = 1'b1;
        w_state_nxt    = EMIT;
      end

      EMIT: begin
        if (w_blk_xfer) begin
          w_idx_nxt = '0;
          if (r_blk_last) begin
            w_len_nxt      = '0;
            w_msg_end_nxt  = 1'b0;
            w_marker_nxt   = 1'b0;
            w_blk_last_nxt = 1'b0;
            w_state_nxt    = ACCUM;
          end else if (r_msg_end && !r_marker) begin
            w_state_nxt = PAD;
          end else if (r_msg_end && r_marker) begin
            w_state_nxt = LEN;
          end else begin
            w_state_nxt = ACCUM;
          end
        end
      end

      default: w_state_nxt = ACCUM;
    endcase
  end

endmodule

// File: tb/tb_sha256_padder.sv
// Self-checking bench for sha256_padder: random and directed messages compared
// against a queue-based model of SHA-256 padding.
module tb_sha256_padder;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [7:0]   in_data;
  logic         in_last;
  logic         blk_valid;
  logic         blk_ready;
  logic [511:0] blk_data;
  logic         blk_last;
  logic         busy;

  int           n_assert = 0;
  int           n_fail   = 0;
  logic [7:0]   msg_q[$];
  logic [511:0] exp_blk_q[$];
  logic [511:0] last_blk;
  logic [511:0] abc_blk;

  sha256_padder dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
    .blk_valid (blk_valid),
    .blk_ready (blk_ready),
    .blk_data  (blk_data),
    .blk_last  (blk_last),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Padded stream = message, 0x80, zeros to 56 mod 64, 8-byte big-endian bit count.
  task automatic build_exp();
    logic [7:0]   p[$];
    logic [63:0]  len_bits;
    logic [511:0] blk;
    p = msg_q;
    len_bits = 64'(msg_q.size()) * 64'd8;
    p.push_back(8'h80);
    while ((p.size() % 64) != 56) p.push_back(8'h00);
    for (int k = 7; k >= 0; k--) p.push_back(len_bits[8*k +: 8]);
    exp_blk_q.delete();
    blk = '0;
    for (int b = 0; b < p.size() / 64; b++) begin
      for (int j = 0; j < 64; j++) blk = {blk[503:0], p[64*b + j]};
      exp_blk_q.push_back(blk);
    end
  endtask

  task automatic make_msg(input int n);
    msg_q.delete();
    for (int i = 0; i < n; i++) msg_q.push_back(8'($urandom_range(0, 255)));
  endtask

  // Called and returns at a negedge. bp holds off the first block for 10 cycles.
  task automatic run_msg(input bit bp, input bit rnd);
    int          n, sent, got, cyc, last_cyc, hold, nblk;
    bit          lat_done, acc;
    logic [511:0] held_data;
    logic         held_last;
    n = msg_q.size();
    sent = 0; got = 0; cyc = 0; last_cyc = -1; lat_done = 0;
    hold = bp ? 10 : 0;
    held_data = '0; held_last = 1'b0;
    build_exp();
    nblk = exp_blk_q.size();
    while (got < nblk && cyc < 20000) begin
      in_valid = (sent < n) && (bp || !rnd || ($urandom_range(0, 3) != 0));
      in_data  = in_valid ? msg_q[sent] : 8'($urandom_range(0, 255));
      in_last  = in_valid && (sent == n - 1);
      if (blk_valid && hold > 0) begin
        blk_ready = 1'b0;
        if (hold == 10) begin
          held_data = blk_data;
          held_last = blk_last;
        end else begin
          check("bp_data_stable", blk_data, held_data);
          check("bp_last_stable", 512'(blk_last), 512'(held_last));
        end
        check("bp_in_ready_low", 512'(in_ready), 512'(0));
        hold--;
      end else begin
        blk_ready = !rnd || ($urandom_range(0, 1) == 1);
      end
      if (blk_valid && !lat_done && last_cyc >= 0) begin
        check("final_latency", 512'(cyc - last_cyc), 512'(((n % 64) == 0) ? 1 : 2));
        lat_done = 1;
      end
      if ((sent % 64) != 0) check("busy_mid", 512'(busy), 512'(1));
      if (blk_valid && blk_ready) begin
        check("blk_data", blk_data, exp_blk_q[got]);
        check("blk_last", 512'(blk_last), 512'(got == nblk - 1));
        last_blk = blk_data;
        got++;
      end
      acc = in_valid && in_ready;
      @(posedge clk);
      if (acc) begin
        if (sent == n - 1) last_cyc = cyc;
        sent++;
      end
      cyc++;
      @(negedge clk);
    end
    in_valid = 1'b0; in_last = 1'b0; blk_ready = 1'b0;
    check("blocks_done", 512'(got), 512'(nblk));
    check("bytes_consumed", 512'(sent), 512'(n));
    check("idle_busy", 512'(busy), 512'(0));
    check("idle_in_ready", 512'(in_ready), 512'(1));
  endtask

  initial begin
    abc_blk   = {32'h61626380, 416'h0, 64'h18};
    last_blk  = '0;
    rst_n     = 1'b1;
    in_valid  = 1'b0;
    in_data   = 8'h00;
    in_last   = 1'b0;
    blk_ready = 1'b0;
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_blk_valid", 512'(blk_valid), 512'(0));
    check("rst_blk_last", 512'(blk_last), 512'(0));
    check("rst_busy", 512'(busy), 512'(0));
    check("rst_blk_data", blk_data, 512'(0));
    rst_n = 1'b1;
    @(negedge clk);
    check("in_ready_after_reset", 512'(in_ready), 512'(1));

    msg_q = '{8'h61, 8'h62, 8'h63};
    run_msg(1'b0, 1'b0);
    check("abc_block", last_blk, abc_blk);

    make_msg(55);
    run_msg(1'b0, 1'b0);
    check("len55_marker", 512'(last_blk[71:64]), 512'(8'h80));
    check("len55_length", 512'(last_blk[63:0]), 512'(64'h1B8));

    make_msg(56);
    run_msg(1'b0, 1'b0);
    check("len56_last_block", last_blk, {448'h0, 64'h1C0});

    make_msg(64);
    run_msg(1'b0, 1'b0);
    check("len64_last_block", last_blk, {8'h80, 440'h0, 64'h200});

    make_msg(70);
    run_msg(1'b1, 1'b0);
    make_msg(10);
    run_msg(1'b0, 1'b0);
    check("back_to_back_length", 512'(last_blk[63:0]), 512'(64'h50));

    for (int t = 0; t < 8; t++) begin
      make_msg($urandom_range(1, 200));
      run_msg(1'b0, 1'b1);
    end
    make_msg(1);   run_msg(1'b0, 1'b1);
    make_msg(119); run_msg(1'b0, 1'b1);
    make_msg(120); run_msg(1'b0, 1'b1);
    make_msg(128); run_msg(1'b0, 1'b1);

    make_msg(40);
    for (int i = 0; i < 30; i++) begin
      in_valid = 1'b1;
      in_data  = msg_q[i];
      in_last  = 1'b0;
      check("partial_in_ready", 512'(in_ready), 512'(1));
      @(posedge clk);
      @(negedge clk);
    end
    in_valid = 1'b0;
    check("partial_busy", 512'(busy), 512'(1));
    #2 rst_n = 1'b0;
    #1;
    check("midrst_blk_valid", 512'(blk_valid), 512'(0));
    check("midrst_blk_last", 512'(blk_last), 512'(0));
    check("midrst_busy", 512'(busy), 512'(0));
    check("midrst_blk_data", blk_data, 512'(0));
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("midrst_in_ready", 512'(in_ready), 512'(1));
    msg_q = '{8'h61, 8'h62, 8'h63};
    run_msg(1'b0, 1'b0);
    check("abc_after_reset", last_blk, abc_blk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
